seq_pattern_gen: RTL and testbench
==================================

Name: seq_pattern_gen

Overview:
- Serial pattern transmitter: the sending end for the sequence detector's 1-bit-per-clock input stream.
- Serializes a loaded PAT_W-bit pattern, MSB first, a programmable number of times, with a programmable idle gap between repeats.
- Uses a start/busy/done handshake and reports a completed-repeat count.
- Sits on the scaled clock domain. Drives either the detector directly or a mux alongside the LFSR for deterministic stimulus and demo modes.

Parameters:
- PAT_W, 8: pattern length in bits (≥2).
- CNT_W, 4: width of repeat_n and sent_count.
- GAP_W, 4: width of gap.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low; 0 at a rising edge resets all state.
- start  in  1  request; sampled only in IDLE.
- pattern  in  PAT_W  bits to send, MSB transmitted first.
- repeat_n  in  CNT_W  number of pattern repetitions; 0 means send nothing.
- gap  in  GAP_W  idle cycles inserted between repeats.
- bit_out  out  1  serial data; 0 whenever bit_valid=0.
- bit_valid  out  1  high in every cycle bit_out carries a pattern bit.
- busy  out  1  high from the cycle after start is accepted until the last bit/gap completes.
- done  out  1  one-cycle pulse at end of request.
- sent_count  out  CNT_W  completed repeats in the current or last request.

Behaviour:
- All outputs are registered.
- Reset (reset=0 at an edge): state=IDLE, bit_out=0, bit_valid=0, busy=0, done=0, sent_count=0, internal shift/bit/gap counters=0. Reset overrides everything, including mid-transfer, and aborts with no done pulse.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - start=1 at edge k latches pattern, repeat_n, gap into internal registers and clears sent_count.
  - If repeat_n≠0: go to SHIFT; busy=1 from cycle k+1.
  - If repeat_n=0: go to DONE; no valid bits.
  - start=0: stay in IDLE.
- SHIFT:
  - bit_valid=1; bit_out=current MSB of the shift register; shift left each cycle.
  - Bit counter runs 0..PAT_W-1, giving exactly PAT_W consecutive valid cycles (k+1..k+PAT_W for the first repeat).
  - On the last bit: sent_count increments (visible the next cycle).
    - If sent_count+1 = latched repeat_n: go to DONE.
    - Else if latched gap=0: reload the shift register from the latched pattern and stay in SHIFT (back-to-back, no bubble).
    - Else: go to GAP.
- GAP: bit_valid=0, bit_out=0, busy=1 for exactly the latched gap cycles, then SHIFT with the pattern reloaded.
- DONE: done=1, busy=0, bit_valid=0 for one cycle; then IDLE.
- Total request length = R·PAT_W + (R−1)·G cycles of SHIFT/GAP. done is asserted in the cycle after the last bit.
- Timing rules:
  - start while busy or in DONE is ignored; no queuing.
  - The earliest new accept is the edge at the end of the DONE cycle? No: the first edge in IDLE, i.e. the cycle after done.
- Input changes to pattern, repeat_n or gap after acceptance have no effect on the request in flight.
- sent_count holds its final value after done until the next accepted start.
- Counter widths: bit counter is ceil(log2(PAT_W)); gap counter is GAP_W; no wrap of sent_count is possible because repeat_n ≤ 2^CNT_W−1.

Test Plan:
- Reset low for 2 cycles, then high, start at edge 0 with pattern=8'b1011_0010, repeat_n=1, gap=0 -> bit_out 1,0,1,1,0,0,1,0 with bit_valid=1 in cycles 1–8; busy=1 in cycles 1–8; done=1 in cycle 9 only; sent_count=1.
- pattern=8'hA5, repeat_n=3, gap=2 -> valid bits in cycles 1–8, 11–18, 21–28; bit_valid=0 and bit_out=0 in cycles 9–10 and 19–20; done in cycle 29; sent_count steps 1, 2, 3.
- pattern=8'hF0, repeat_n=2, gap=0 -> 16 contiguous valid cycles (1–16) reading F0F0 MSB-first; done in cycle 17.
- repeat_n=0 with start -> no bit_valid; busy stays 0; done=1 in cycle 1; sent_count=0.
- During a repeat_n=3 request, pulse start and change pattern to 8'h00 in cycle 4 -> output stream unchanged from the original pattern; single done. Then start in the cycle after done -> new request begins with its first bit one cycle later.
- Drive reset=0 at cycle 5 of a repeat_n=2 request -> from cycle 6 bit_valid=0, bit_out=0, busy=0, sent_count=0, and no done pulse is ever produced.

Source files
------------

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial pattern transmitter.
// Sends a latched PAT_W-bit pattern MSB first, repeat_n times, with gap idle
// cycles between repeats. A start/busy/done handshake frames each request.
// Ports:
//   clk        - clock, all logic on the rising edge
//   reset      - synchronous active-low reset
//   start      - request, sampled only while idle
//   pattern    - bits to send, MSB first
//   repeat_n   - number of repetitions (0 = send nothing, just done)
//   gap        - idle cycles between repeats
//   bit_out    - serial data, 0 whenever bit_valid is low
//   bit_valid  - high while bit_out carries a pattern bit
//   busy       - high while shifting or in a gap
//   done       - one-cycle pulse at the end of a request
//   sent_count - completed repeats of the current or last request
module seq_pattern_gen #(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned GAP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic [GAP_W-1:0] gap,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent_count
);

  localparam int unsigned BIT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]       state_q,     state_d;
  logic [PAT_W-1:0] shift_q,     shift_d;
  logic [PAT_W-1:0] pat_q,       pat_d;
  logic [CNT_W-1:0] rep_q,       rep_d;
  logic [GAP_W-1:0] gap_lat_q,   gap_lat_d;
  logic [BIT_W-1:0] bit_cnt_q,   bit_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q,   gap_cnt_d;
  logic [CNT_W-1:0] sent_q,      sent_d;
  logic             bit_out_q,   bit_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;

  logic [CNT_W-1:0] sent_inc;

  assign sent_inc = sent_q + CNT_W'(1);

  // Next-state logic; output flops are loaded from the next state so that
  // every output reflects the state of the cycle it is visible in.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    pat_d     = pat_q;
    rep_d     = rep_q;
    gap_lat_d = gap_lat_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    sent_d    = sent_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pat_d     = pattern;
          rep_d     = repeat_n;
          gap_lat_d = gap;
          sent_d    = '0;
          bit_cnt_d = '0;
          gap_cnt_d = '0;
          shift_d   = pattern;
          state_d   = (repeat_n != '0) ? ST_SHIFT : ST_DONE;
        end
      end

      ST_SHIFT: begin
        shift_d   = {shift_q[PAT_W-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + BIT_W'(1);
        if (bit_cnt_q == BIT_W'(PAT_W - 1)) begin
          bit_cnt_d = '0;
          sent_d    = sent_inc;
          if (sent_inc == rep_q) begin
            state_d = ST_DONE;
          end else if (gap_lat_q == '0) begin
            // back-to-back repeat, no bubble
            shift_d = pat_q;
          end else begin
            gap_cnt_d = '0;
            state_d   = ST_GAP;
          end
        end
      end

      ST_GAP: begin
        gap_cnt_d = gap_cnt_q + GAP_W'(1);
        if (gap_cnt_q == gap_lat_q - GAP_W'(1)) begin
          gap_cnt_d = '0;
          shift_d   = pat_q;
          state_d   = ST_SHIFT;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    bit_valid_d = (state_d == ST_SHIFT);
    bit_out_d   = bit_valid_d & shift_d[PAT_W-1];
    busy_d      = (state_d == ST_SHIFT) || (state_d == ST_GAP);
    done_d      = (state_d == ST_DONE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      pat_q       <= '0;
      rep_q       <= '0;
      gap_lat_q   <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      sent_q      <= '0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      pat_q       <= pat_d;
      rep_q       <= rep_d;
      gap_lat_q   <= gap_lat_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      sent_q      <= sent_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bit_out    = bit_out_q;
  assign bit_valid  = bit_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sent_count = sent_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Testbench for seq_pattern_gen: directed requests plus random traffic,
// compared cycle by cycle against a queue-based model of the output stream.
module tb_seq_pattern_gen;

  localparam int unsigned PAT_W = 8;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned GAP_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] repeat_n;
  logic [GAP_W-1:0] gap;
  logic             bit_out;
  logic             bit_valid;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] sent_count;

  always #5 clk = ~clk;

  seq_pattern_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pattern    (pattern),
    .repeat_n   (repeat_n),
    .gap        (gap),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .busy       (busy),
    .done       (done),
    .sent_count (sent_count)
  );

  // Expected outputs for one cycle.
  typedef struct packed {
    logic             valid;
    logic             bit_o;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sent;
  } exp_t;

  exp_t cur;
  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", tag, cyc, got, want);
    end
  endtask

  // Expand an accepted request into its full per-cycle output stream.
  task automatic build_request(input logic [PAT_W-1:0] pat, input int unsigned reps,
                               input int unsigned gp);
    exp_t e;
    int unsigned sc = 0;
    for (int unsigned r = 0; r < reps; r++) begin
      for (int b = int'(PAT_W) - 1; b >= 0; b--) begin
        e = '{valid: 1'b1, bit_o: pat[b], busy: 1'b1, done: 1'b0, sent: CNT_W'(sc)};
        exp_q.push_back(e);
      end
      sc++;
      if (r + 1 < reps) begin
        for (int unsigned g = 0; g < gp; g++) begin
          e = '{valid: 1'b0, bit_o: 1'b0, busy: 1'b1, done: 1'b0, sent: CNT_W'(sc)};
          exp_q.push_back(e);
        end
      end
    end
    e = '{valid: 1'b0, bit_o: 1'b0, busy: 1'b0, done: 1'b1, sent: CNT_W'(sc)};
    exp_q.push_back(e);
  endtask

  // Advance the model across one rising edge using the inputs seen there.
  task automatic model_edge();
    exp_t e;
    if (!reset) begin
      exp_q.delete();
      cur = '0;
    end else if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
    end else if (cur.done || !start) begin
      e      = '0;
      e.sent = cur.sent;
      cur    = e;
    end else begin
      build_request(pattern, int'(repeat_n), int'(gap));
      cur = exp_q.pop_front();
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
    chk("bit_valid",  32'(bit_valid),  32'(cur.valid));
    chk("bit_out",    32'(bit_out),    32'(cur.bit_o));
    chk("busy",       32'(busy),       32'(cur.busy));
    chk("done",       32'(done),       32'(cur.done));
    chk("sent_count", 32'(sent_count), 32'(cur.sent));
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while ((exp_q.size() != 0 || cur.done || cur.busy) && n < max_cycles) begin
      step();
      n++;
    end
    if (n >= max_cycles) chk("wait_bound", 32'(n), 32'(max_cycles - 1));
  endtask

  task automatic request(input logic [PAT_W-1:0] pat, input logic [CNT_W-1:0] reps,
                         input logic [GAP_W-1:0] gp);
    pattern  = pat;
    repeat_n = reps;
    gap      = gp;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    pattern  = '0;
    repeat_n = '0;
    gap      = '0;
    cur      = '0;

    step();
    step();
    reset = 1'b1;
    step();

    // single repeat of 1011_0010
    request(8'b1011_0010, 4'd1, 4'd0);
    chk("b2_first_bit", 32'(bit_out), 32'd1);
    wait_idle(100);
    chk("b2_sent_final", 32'(sent_count), 32'd1);

    // three repeats with a two-cycle gap
    request(8'hA5, 4'd3, 4'd2);
    wait_idle(100);
    chk("a5_sent_final", 32'(sent_count), 32'd3);

    // back-to-back repeats
    request(8'hF0, 4'd2, 4'd0);
    wait_idle(100);
    step();

    // repeat_n = 0: done only
    request(8'hFF, 4'd0, 4'd3);
    chk("zero_rep_done", 32'(done), 32'd1);
    chk("zero_rep_busy", 32'(busy), 32'd0);
    wait_idle(10);

    // start and pattern change while busy are ignored; restart after done
    request(8'h3C, 4'd3, 4'd1);
    step();
    step();
    start   = 1'b1;
    pattern = 8'h00;
    step();
    start   = 1'b0;
    for (int i = 0; i < 100 && !cur.done; i++) step();
    chk("busy_req_done", 32'(done), 32'd1);
    pattern  = 8'h81;
    repeat_n = 4'd1;
    gap      = 4'd0;
    start    = 1'b1;
    step();
    chk("done_cycle_ignored", 32'(bit_valid), 32'd0);
    step();
    start = 1'b0;
    chk("restart_valid", 32'(bit_valid), 32'd1);
    wait_idle(100);

    // reset in the middle of a request
    request(8'hC3, 4'd2, 4'd1);
    for (int i = 0; i < 4; i++) step();
    reset = 1'b0;
    step();
    chk("abort_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 30; i++) step();

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      start    = ($urandom_range(0, 3) == 0);
      pattern  = PAT_W'($urandom);
      repeat_n = CNT_W'($urandom_range(0, 4));
      gap      = GAP_W'($urandom_range(0, 3));
      reset    = ($urandom_range(0, 79) != 0);
      step();
    end
    reset = 1'b1;
    start = 1'b0;
    wait_idle(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
